evt_window_ctrl: RTL and testbench
==================================

# evt_window_ctrl

Measurement-window controller for the receive-signal path. On a start request it runs a sweep of NUM_WINDOWS back-to-back measurement windows. Each window waits a settle interval, counts `evt_in` pulses for exactly WINDOW_CYCLES clocks, then presents the count downstream on a valid/ready handshake. It sits between the depth-scan sequencer (start/abort) and the result capture logic (count consumer).

## Interface
- WINDOW_CYCLES, 1000: clocks per counting window (≥1)
- SETTLE_CYCLES, 16: idle clocks before each window (0 allowed: settle skipped)
- NUM_WINDOWS, 4: windows per sweep (≥1)
- COUNT_WIDTH, 16: width of count_out
- clk_in  input  1  system clock; single clock domain, all logic on posedge
- rst_in  input  1  synchronous, active-low reset
- start_in  input  1  sweep request; sampled only in IDLE
- abort_in  input  1  cancel sweep; any state
- evt_in  input  1  event strobe, one count per high cycle
- ready_in  input  1  consumer ready
- valid_out  output  1  count_out/window_idx_out valid
- count_out  output  COUNT_WIDTH  events in the completed window
- window_idx_out  output  max(1,$clog2(NUM_WINDOWS))  index of the window being reported
- overflow_out  output  1  count saturated in the reported window
- busy_out  output  1  high in any state except IDLE
- done_out  output  1  one-cycle pulse when the sweep completes normally

## Operation
- States: IDLE, SETTLE, COUNT, HOLD.
- IDLE + start_in → SETTLE, or → COUNT if SETTLE_CYCLES=0. The window index is cleared to 0.
- SETTLE: stays SETTLE_CYCLES clocks → COUNT. The event counter is cleared on entry to COUNT.
- COUNT: stays exactly WINDOW_CYCLES clocks. `evt_in` is sampled every COUNT cycle and added.
  - The counter saturates at 2^COUNT_WIDTH−1.
  - An event arriving while the counter is saturated sets a sticky per-window overflow.
- COUNT → HOLD: count, index and overflow are latched into output registers, and valid_out rises.
- HOLD: outputs stay stable until valid_out && ready_in. On the handshake cycle:
  - if the index is not the last, the index increments and the state → SETTLE (or COUNT);
  - else the state → IDLE and done_out pulses the next cycle.
- Events outside COUNT (IDLE/SETTLE/HOLD) are ignored.
- start_in while busy is ignored.
- abort_in (any non-IDLE state):
  - next state IDLE;
  - valid_out, busy_out and done_out are 0 the following cycle;
  - partial counts are discarded.
- Priority: abort_in over handshake/timer.
- Reset (rst_in low on a clock edge), at any point, forces IDLE. Every output resets to 0: valid_out, count_out, window_idx_out, overflow_out, busy_out, done_out.

## Timing
- start_in high at edge T: busy_out high from T+1.
- SETTLE occupies cycles T+1..T+SETTLE_CYCLES.
- COUNT occupies the next WINDOW_CYCLES cycles.
- valid_out is high from the cycle after the last COUNT cycle, so latency start→valid = SETTLE_CYCLES+WINDOW_CYCLES+1.
- Handshake at edge H, next window: SETTLE starts at H+1; no bubble beyond SETTLE_CYCLES.
- Handshake at edge H, last window: busy_out low and done_out high at H+1; done_out is low at H+2.
- A new start_in is accepted from the cycle busy_out is low (same cycle as done_out).
- Inter-window gap with ready_in held high: one HOLD cycle + SETTLE_CYCLES.

## Structure
- Shared package evt_pkg holds:
  - the state enum typedef (IDLE, SETTLE, COUNT, HOLD);
  - the localparam computing the index width.
- One natural sub-module, gated_evt_counter. It has clear, enable and saturation, and outputs count plus the sticky overflow flag.
- The phase timer (settle/window down-counter) and FSM live in evt_window_ctrl.

## Test plan
Bench parameters unless noted: WINDOW_CYCLES=8, SETTLE_CYCLES=2, NUM_WINDOWS=2, COUNT_WIDTH=4, ready_in=1.
- evt_in held high, one start pulse:
  - two valid beats, count_out=8 with idx 0, then count_out=8 with idx 1;
  - first valid_out at start+11;
  - done_out is a single pulse after the second handshake.
- evt_in high only during SETTLE and HOLD cycles → count_out=0 for both windows.
- COUNT_WIDTH=3, evt_in high throughout → count_out=7, overflow_out=1. The next window with evt_in low reports 0 with overflow_out=0.
- ready_in low for 5 cycles after valid_out rises, toggling evt_in meanwhile:
  - valid_out stays high;
  - count_out and idx stay unchanged;
  - the handshake completes on the cycle ready_in returns high.
- abort_in pulsed at COUNT cycle 4:
  - the next cycle has busy_out=0 and valid_out=0;
  - no done_out pulse;
  - a fresh start then produces idx 0 and count 8.
- rst_in low for one cycle during HOLD → all outputs 0 the next cycle; start_in while busy (before reset) is ignored.

Source files
------------

// File: rtl/evt_pkg.sv
// Shared types for the measurement-window controller: FSM states and window-index sizing.
package evt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    HOLD   = 2'd3
  } evt_state_e;

  localparam int DEFAULT_NUM_WINDOWS = 4;

  // A single-window sweep still needs a one-bit index port.
  function automatic int idx_width(input int num_windows);
    return (num_windows > 1) ? $clog2(num_windows) : 1;
  endfunction

endpackage

// File: rtl/evt_window_ctrl_if.sv
// Signal bundle between the depth-scan sequencer, the window controller and result capture.
interface evt_window_ctrl_if
  import evt_pkg::*;
#(
  parameter int COUNT_WIDTH = 16,
  parameter int NUM_WINDOWS = DEFAULT_NUM_WINDOWS
) ();

  localparam int IDX_W = idx_width(NUM_WINDOWS);

  logic                   start_in;
  logic                   abort_in;
  logic                   evt_in;
  logic                   ready_in;
  logic                   valid_out;
  logic [COUNT_WIDTH-1:0] count_out;
  logic [IDX_W-1:0]       window_idx_out;
  logic                   overflow_out;
  logic                   busy_out;
  logic                   done_out;

  modport master (
    output start_in, abort_in, evt_in, ready_in,
    input  valid_out, count_out, window_idx_out, overflow_out, busy_out, done_out
  );

  modport slave (
    input  start_in, abort_in, evt_in, ready_in,
    output valid_out, count_out, window_idx_out, overflow_out, busy_out, done_out
  );

endinterface

// File: rtl/gated_evt_counter.sv
// Saturating event counter with a sticky overflow flag. The outputs present the value
// including the current cycle's event, so the parent can latch a complete window in one edge.
module gated_evt_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   evt,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};

  logic [COUNT_WIDTH-1:0] cnt_r;
  logic [COUNT_WIDTH-1:0] cnt_s;
  logic                   ovf_r;
  logic                   ovf_s;

  // Clear wins over counting; an event at saturation only raises the sticky flag.
  always_comb begin
    cnt_s = cnt_r;
    ovf_s = ovf_r;
    if (clr) begin
      cnt_s = CNT_ZERO;
      ovf_s = 1'b0;
    end else if (en && evt) begin
      if (cnt_r == CNT_MAX) begin
        ovf_s = 1'b1;
      end else begin
        cnt_s = cnt_r + COUNT_WIDTH'(1'b1);
      end
    end else begin
      cnt_s = cnt_r;
      ovf_s = ovf_r;
    end
  end

  // Counter state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_r <= CNT_ZERO;
      ovf_r <= 1'b0;
    end else begin
      cnt_r <= cnt_s;
      ovf_r <= ovf_s;
    end
  end

  assign count    = cnt_s;
  assign overflow = ovf_s;

endmodule

// File: rtl/evt_window_ctrl.sv
// Measurement-window controller: each start runs NUM_WINDOWS settle/count windows and hands
// every window's event count downstream on a valid/ready handshake.
module evt_window_ctrl
  import evt_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int SETTLE_CYCLES = 16,
  parameter int NUM_WINDOWS   = DEFAULT_NUM_WINDOWS,
  parameter int COUNT_WIDTH   = 16
) (
  input logic              clk_in,
  input logic              rst_in,
  evt_window_ctrl_if.slave bus
);

  localparam int IDX_W    = idx_width(NUM_WINDOWS);
  localparam int TMR_SPAN = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W    = (TMR_SPAN > 1) ? $clog2(TMR_SPAN) : 1;
  localparam logic [TMR_W-1:0] WIN_LOAD    = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_ZERO    = {TMR_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ZERO    = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_WINDOWS - 1);
  localparam bit               SKIP_SETTLE = (SETTLE_CYCLES == 0);

  evt_state_e             state_r;
  evt_state_e             state_s;
  logic [TMR_W-1:0]       timer_r;
  logic [TMR_W-1:0]       timer_s;
  logic [IDX_W-1:0]       idx_r;
  logic [IDX_W-1:0]       idx_s;
  logic [IDX_W-1:0]       idx_out_r;
  logic [COUNT_WIDTH-1:0] count_out_r;
  logic [COUNT_WIDTH-1:0] cnt_s;
  logic                   ovf_s;
  logic                   ovf_out_r;
  logic                   valid_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   done_s;
  logic                   clr_s;
  logic                   en_s;
  logic                   abort_s;
  logic                   handshake_s;
  logic                   timer_done_s;

  gated_evt_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_counter (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clr      (clr_s),
    .en       (en_s),
    .evt      (bus.evt_in),
    .count    (cnt_s),
    .overflow (ovf_s)
  );

  assign en_s         = (state_r == COUNT);
  assign abort_s      = bus.abort_in && (state_r != IDLE);
  assign handshake_s  = valid_r && bus.ready_in;
  assign timer_done_s = (timer_r == TMR_ZERO);

  // Next state, phase timer and window index; a window entry skips SETTLE when it has no length.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    idx_s   = idx_r;
    clr_s   = 1'b0;
    done_s  = 1'b0;
    if (abort_s) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start_in) begin
            idx_s = IDX_ZERO;
            if (SKIP_SETTLE) begin
              state_s = COUNT;
              timer_s = WIN_LOAD;
              clr_s   = 1'b1;
            end else begin
              state_s = SETTLE;
              timer_s = SETTLE_LOAD;
            end
          end else begin
            state_s = IDLE;
          end
        end
        SETTLE: begin
          if (timer_done_s) begin
            state_s = COUNT;
            timer_s = WIN_LOAD;
            clr_s   = 1'b1;
          end else begin
            timer_s = timer_r - TMR_W'(1'b1);
          end
        end
        COUNT: begin
          if (timer_done_s) begin
            state_s = HOLD;
          end else begin
            timer_s = timer_r - TMR_W'(1'b1);
          end
        end
        HOLD: begin
          if (!handshake_s) begin
            state_s = HOLD;
          end else if (idx_r == LAST_IDX) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            idx_s = idx_r + IDX_W'(1'b1);
            if (SKIP_SETTLE) begin
              state_s = COUNT;
              timer_s = WIN_LOAD;
              clr_s   = 1'b1;
            end else begin
              state_s = SETTLE;
              timer_s = SETTLE_LOAD;
            end
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // FSM registers and registered outputs; results load only on the COUNT->HOLD edge.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r     <= IDLE;
      timer_r     <= TMR_ZERO;
      idx_r       <= IDX_ZERO;
      idx_out_r   <= IDX_ZERO;
      count_out_r <= {COUNT_WIDTH{1'b0}};
      ovf_out_r   <= 1'b0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      idx_r   <= idx_s;
      valid_r <= (state_s == HOLD);
      busy_r  <= (state_s != IDLE);
      done_r  <= done_s;
      if ((state_r == COUNT) && (state_s == HOLD)) begin
        count_out_r <= cnt_s;
        ovf_out_r   <= ovf_s;
        idx_out_r   <= idx_r;
      end else begin
        count_out_r <= count_out_r;
        ovf_out_r   <= ovf_out_r;
        idx_out_r   <= idx_out_r;
      end
    end
  end

  assign bus.valid_out      = valid_r;
  assign bus.count_out      = count_out_r;
  assign bus.window_idx_out = idx_out_r;
  assign bus.overflow_out   = ovf_out_r;
  assign bus.busy_out       = busy_r;
  assign bus.done_out       = done_r;

endmodule

// File: tb/tb_evt_window_ctrl.sv
// Bench for evt_window_ctrl: directed scenarios plus randomized sweeps checked against a
// timing/arithmetic model of the window schedule (count edges follow each acceptance edge).
module tb_evt_window_ctrl;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int NW = 2;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   evt_log [int];

  evt_window_ctrl_if #(.COUNT_WIDTH(4), .NUM_WINDOWS(NW)) bus_a ();
  evt_window_ctrl_if #(.COUNT_WIDTH(3), .NUM_WINDOWS(NW)) bus_b ();

  evt_window_ctrl #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .NUM_WINDOWS(NW), .COUNT_WIDTH(4)) dut_a (
    .clk_in (clk_in),
    .rst_in (rst_n),
    .bus    (bus_a)
  );

  evt_window_ctrl #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .NUM_WINDOWS(NW), .COUNT_WIDTH(3)) dut_b (
    .clk_in (clk_in),
    .rst_in (rst_n),
    .bus    (bus_b)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // After tick() the DUT state reflects edge number cyc; inputs set before it were sampled there.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (bus_a.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus_a.valid_out); end
    n_checks++; if (bus_a.count_out !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus_a.count_out); end
    n_checks++; if (bus_a.window_idx_out !== 1'b0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus_a.window_idx_out); end
    n_checks++; if (bus_a.overflow_out !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus_a.overflow_out); end
    n_checks++; if (bus_a.busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy_out); end
    n_checks++; if (bus_a.done_out !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus_a.done_out); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_sweep();
    int t0, beats, dones, done_at, last_hs;
    bus_a.evt_in = 1'b1; bus_a.ready_in = 1'b1; bus_a.start_in = 1'b1;
    tick();
    bus_a.start_in = 1'b0;
    t0 = cyc;
    n_checks++; if (bus_a.busy_out !== 1'b1) begin n_fail++; $display("FAIL sweep_busy: got %b expected 1", bus_a.busy_out); end
    beats = 0; dones = 0; done_at = -1; last_hs = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus_a.valid_out === 1'b1) begin
        n_checks++; if (cyc !== t0 + beats * (W + S + 1) + S + W) begin n_fail++; $display("FAIL sweep_valid_time: got %0d expected %0d", cyc - t0, beats * (W + S + 1) + S + W); end
        n_checks++; if (bus_a.count_out !== 4'd8) begin n_fail++; $display("FAIL sweep_count: got %0d expected 8", bus_a.count_out); end
        n_checks++; if (bus_a.window_idx_out !== 1'(beats)) begin n_fail++; $display("FAIL sweep_idx: got %0d expected %0d", bus_a.window_idx_out, beats); end
        beats++;
        last_hs = cyc + 1;
      end
      if (bus_a.done_out === 1'b1) begin dones++; done_at = cyc; end
      tick();
    end
    n_checks++; if (beats !== 2) begin n_fail++; $display("FAIL sweep_beats: got %0d expected 2", beats); end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL sweep_done_pulses: got %0d expected 1", dones); end
    n_checks++; if (done_at !== last_hs) begin n_fail++; $display("FAIL sweep_done_time: got %0d expected %0d", done_at, last_hs); end
    bus_a.evt_in = 1'b0;
  endtask

  task automatic test_gated_events();
    int t0, beats, e, k, rel;
    bus_a.ready_in = 1'b1; bus_a.evt_in = 1'b1; bus_a.start_in = 1'b1;
    tick();
    bus_a.start_in = 1'b0;
    t0 = cyc; beats = 0;
    for (int i = 0; i < 30; i++) begin
      e = cyc + 1; k = (e - t0) / (W + S + 1); rel = (e - t0) % (W + S + 1);
      bus_a.evt_in = ((k < NW) && (rel >= S + 1) && (rel <= S + W)) ? 1'b0 : 1'b1;
      tick();
      if (bus_a.valid_out === 1'b1) begin
        n_checks++; if (bus_a.count_out !== 4'd0) begin n_fail++; $display("FAIL gated_count: got %0d expected 0", bus_a.count_out); end
        n_checks++; if (bus_a.window_idx_out !== 1'(beats)) begin n_fail++; $display("FAIL gated_idx: got %0d expected %0d", bus_a.window_idx_out, beats); end
        beats++;
      end
    end
    n_checks++; if (beats !== 2) begin n_fail++; $display("FAIL gated_beats: got %0d expected 2", beats); end
    bus_a.evt_in = 1'b0;
  endtask

  task automatic test_saturation();
    int beats;
    bus_b.ready_in = 1'b1; bus_b.evt_in = 1'b1; bus_b.start_in = 1'b1;
    tick();
    bus_b.start_in = 1'b0;
    beats = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_b.valid_out === 1'b1) begin
        if (beats == 0) begin
          n_checks++; if (bus_b.count_out !== 3'd7) begin n_fail++; $display("FAIL sat_count: got %0d expected 7", bus_b.count_out); end
          n_checks++; if (bus_b.overflow_out !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b expected 1", bus_b.overflow_out); end
          bus_b.evt_in = 1'b0;
        end else begin
          n_checks++; if (bus_b.count_out !== 3'd0) begin n_fail++; $display("FAIL sat_next_count: got %0d expected 0", bus_b.count_out); end
          n_checks++; if (bus_b.overflow_out !== 1'b0) begin n_fail++; $display("FAIL sat_next_ovf: got %b expected 0", bus_b.overflow_out); end
        end
        beats++;
      end
    end
    n_checks++; if (beats !== 2) begin n_fail++; $display("FAIL sat_beats: got %0d expected 2", beats); end
  endtask

  task automatic test_backpressure();
    bit seen_done, seen_second;
    bus_a.ready_in = 1'b0; bus_a.evt_in = 1'b1; bus_a.start_in = 1'b1;
    tick();
    bus_a.start_in = 1'b0;
    for (int i = 0; i < 20 && bus_a.valid_out !== 1'b1; i++) tick();
    n_checks++; if (bus_a.valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout: got %b expected 1", bus_a.valid_out); end
    for (int i = 0; i < 5; i++) begin
      bus_a.evt_in = 1'($urandom_range(0, 1));
      tick();
      n_checks++; if (bus_a.valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold: got %b expected 1", bus_a.valid_out); end
      n_checks++; if (bus_a.count_out !== 4'd8) begin n_fail++; $display("FAIL bp_count_hold: got %0d expected 8", bus_a.count_out); end
      n_checks++; if (bus_a.window_idx_out !== 1'b0) begin n_fail++; $display("FAIL bp_idx_hold: got %0d expected 0", bus_a.window_idx_out); end
    end
    bus_a.ready_in = 1'b1;
    tick();
    bus_a.evt_in = 1'b0;
    n_checks++; if (bus_a.valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_handshake: got valid %b expected 0", bus_a.valid_out); end
    n_checks++; if (bus_a.busy_out !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got %b expected 1", bus_a.busy_out); end
    seen_done = 1'b0; seen_second = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_a.valid_out === 1'b1) begin
        seen_second = 1'b1;
        n_checks++; if (bus_a.count_out !== 4'd0 || bus_a.window_idx_out !== 1'b1) begin n_fail++; $display("FAIL bp_second: got count %0d idx %0d expected 0 idx 1", bus_a.count_out, bus_a.window_idx_out); end
      end
      if (bus_a.done_out === 1'b1) seen_done = 1'b1;
    end
    n_checks++; if (!(seen_second && seen_done)) begin n_fail++; $display("FAIL bp_finish: got second %b done %b expected 1 1", seen_second, seen_done); end
  endtask

  task automatic test_abort();
    int t1, n_valid, n_done;
    bus_a.ready_in = 1'b1; bus_a.evt_in = 1'b1; bus_a.start_in = 1'b1;
    tick();
    bus_a.start_in = 1'b0;
    for (int i = 0; i < S + 3; i++) tick();
    bus_a.abort_in = 1'b1;
    tick();
    bus_a.abort_in = 1'b0;
    n_checks++; if (bus_a.busy_out !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus_a.busy_out); end
    n_checks++; if (bus_a.valid_out !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", bus_a.valid_out); end
    n_valid = 0; n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_a.done_out === 1'b1) n_done++;
      if (bus_a.valid_out === 1'b1) n_valid++;
      tick();
    end
    n_checks++; if (n_done !== 0 || n_valid !== 0) begin n_fail++; $display("FAIL abort_quiet: got done %0d valid %0d expected 0 0", n_done, n_valid); end
    bus_a.start_in = 1'b1;
    tick();
    bus_a.start_in = 1'b0;
    t1 = cyc;
    for (int i = 0; i < 20 && bus_a.valid_out !== 1'b1; i++) tick();
    n_checks++; if (cyc !== t1 + S + W) begin n_fail++; $display("FAIL abort_restart_time: got %0d expected %0d", cyc - t1, S + W); end
    n_checks++; if (bus_a.count_out !== 4'd8 || bus_a.window_idx_out !== 1'b0) begin n_fail++; $display("FAIL abort_restart: got count %0d idx %0d expected 8 idx 0", bus_a.count_out, bus_a.window_idx_out); end
    for (int i = 0; i < 16; i++) tick();
    bus_a.evt_in = 1'b0;
    n_checks++; if (bus_a.busy_out !== 1'b0) begin n_fail++; $display("FAIL abort_restart_idle: got busy %b expected 0", bus_a.busy_out); end
  endtask

  task automatic test_random();
    int a_edge, k, sum, held;
    bit prev_valid, ev, rd;
    for (int s = 0; s < 3; s++) begin
      bus_a.start_in = 1'b1;
      tick();
      bus_a.start_in = 1'b0;
      a_edge = cyc; k = 0; prev_valid = 1'b0; held = 0;
      for (int i = 0; i < 200 && k < NW; i++) begin
        ev = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
        bus_a.evt_in = ev; bus_a.ready_in = rd;
        tick();
        evt_log[cyc] = ev;
        if (prev_valid && rd) begin
          k++; a_edge = cyc; prev_valid = 1'b0;
          if (k == NW) begin
            n_checks++; if (bus_a.done_out !== 1'b1 || bus_a.busy_out !== 1'b0) begin n_fail++; $display("FAIL rand_done: got done %b busy %b expected 1 0", bus_a.done_out, bus_a.busy_out); end
          end else begin
            n_checks++; if (bus_a.valid_out !== 1'b0) begin n_fail++; $display("FAIL rand_hs_valid: got %b expected 0", bus_a.valid_out); end
          end
        end else if (cyc == a_edge + S + W) begin
          sum = 0;
          for (int e = a_edge + S + 1; e <= a_edge + S + W; e++) sum += int'(evt_log[e]);
          held = (sum > 15) ? 15 : sum;
          prev_valid = 1'b1;
          n_checks++; if (bus_a.valid_out !== 1'b1) begin n_fail++; $display("FAIL rand_valid_rise: got %b expected 1", bus_a.valid_out); end
          n_checks++; if (bus_a.count_out !== 4'(held)) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", bus_a.count_out, held); end
          n_checks++; if (bus_a.window_idx_out !== 1'(k) || bus_a.overflow_out !== 1'(sum > 15)) begin n_fail++; $display("FAIL rand_idx_ovf: got idx %0d ovf %b expected %0d %b", bus_a.window_idx_out, bus_a.overflow_out, k, sum > 15); end
        end else begin
          n_checks++; if (bus_a.valid_out !== prev_valid) begin n_fail++; $display("FAIL rand_valid: got %b expected %b", bus_a.valid_out, prev_valid); end
          if (prev_valid) begin
            n_checks++; if (bus_a.count_out !== 4'(held)) begin n_fail++; $display("FAIL rand_count_hold: got %0d expected %0d", bus_a.count_out, held); end
          end
        end
      end
      n_checks++; if (k !== NW) begin n_fail++; $display("FAIL rand_timeout: got %0d windows expected %0d", k, NW); end
      bus_a.evt_in = 1'b0; bus_a.ready_in = 1'b1;
      tick();
      n_checks++; if (bus_a.done_out !== 1'b0) begin n_fail++; $display("FAIL rand_done_pulse: got %b expected 0", bus_a.done_out); end
    end
  endtask

  task automatic test_reset_in_hold();
    int t0;
    bus_a.ready_in = 1'b0; bus_a.evt_in = 1'b1; bus_a.start_in = 1'b1;
    tick();
    bus_a.start_in = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 3; i++) tick();
    bus_a.start_in = 1'b1;
    tick();
    bus_a.start_in = 1'b0;
    for (int i = 0; i < 20 && bus_a.valid_out !== 1'b1; i++) tick();
    n_checks++; if (cyc !== t0 + S + W) begin n_fail++; $display("FAIL busy_start_ignored: got %0d expected %0d", cyc - t0, S + W); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (bus_a.valid_out !== 1'b0 || bus_a.busy_out !== 1'b0 || bus_a.done_out !== 1'b0) begin n_fail++; $display("FAIL hold_reset_flags: got valid %b busy %b done %b expected 0 0 0", bus_a.valid_out, bus_a.busy_out, bus_a.done_out); end
    n_checks++; if (bus_a.count_out !== 4'd0 || bus_a.window_idx_out !== 1'b0 || bus_a.overflow_out !== 1'b0) begin n_fail++; $display("FAIL hold_reset_data: got count %0d idx %0d ovf %b expected 0 0 0", bus_a.count_out, bus_a.window_idx_out, bus_a.overflow_out); end
    rst_n = 1'b1; bus_a.evt_in = 1'b0;
    tick();
    tick();
    n_checks++; if (bus_a.busy_out !== 1'b0 || bus_a.valid_out !== 1'b0) begin n_fail++; $display("FAIL hold_reset_idle: got busy %b valid %b expected 0 0", bus_a.busy_out, bus_a.valid_out); end
  endtask

  initial begin
    bus_a.start_in = 1'b0; bus_a.abort_in = 1'b0; bus_a.evt_in = 1'b0; bus_a.ready_in = 1'b0;
    bus_b.start_in = 1'b0; bus_b.abort_in = 1'b0; bus_b.evt_in = 1'b0; bus_b.ready_in = 1'b0;
    test_reset();
    test_full_sweep();
    test_gated_events();
    test_saturation();
    test_backpressure();
    test_abort();
    test_random();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
